// File: rtl/mux_scan_reg.sv
// Registered N-way channel selector with manual, auto-scan, step and hold modes.
// The selected channel index is held in sel; y carries the data of the channel selected one cycle earlier.
module mux_scan_reg #(
  parameter  int W     = 2,
  parameter  int N     = 4,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     d,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               step,
  output logic [W-1:0]       y,
  output logic [SEL_W-1:0]   sel,
  output logic               chg
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [SEL_W-1:0] sel_next;
  logic [SEL_W-1:0] sel_adv;
  logic             step_d;
  logic             step_edge;
  logic             in_range;
  logic [W-1:0]     ch [N];

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = d[k*W +: W];
  end

  assign step_edge = step & ~step_d;
  assign sel_adv   = (sel == SEL_LAST) ? '0 : sel + 1'b1;
  // Widened by one bit so N = 2**SEL_W still compares correctly.
  assign in_range  = ({1'b0, sel_in} < (SEL_W + 1)'(N));

  // The dwell counter only runs in scan mode, so every scan entry starts a full dwell.
  always_comb begin
    sel_next = sel;
    cnt_next = '0;
    case (mode_e'(mode))
      MODE_MANUAL: if (in_range) sel_next = sel_in;
      MODE_SCAN: begin
        if (cnt == CNT_LAST) sel_next = sel_adv;
        else                 cnt_next = cnt + 1'b1;
      end
      MODE_STEP:   if (step_edge) sel_next = sel_adv;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel    <= '0;
      cnt    <= '0;
      step_d <= 1'b0;
      chg    <= 1'b0;
      y      <= '0;
    end else begin
      sel    <= sel_next;
      cnt    <= cnt_next;
      step_d <= step;
      chg    <= (sel_next != sel);
      if (mode_e'(mode) != MODE_HOLD) y <= ch[sel];
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: directed vector table, randomized run against a reference model,
// and short sequences for N=3 and DWELL=1 builds.
module tb_mux_scan_reg;

  localparam int W = 2, N = 4, DWELL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic       rst_n, step;
  logic [1:0] mode, sel_in;
  logic [7:0] d;
  logic [1:0] y, sel;
  logic       chg;

  // N=3 and DWELL=1 instances
  logic       aux_step;
  logic       n3_rst_n, d1_rst_n;
  logic [1:0] n3_mode, n3_sel_in, d1_mode, d1_sel_in;
  logic [5:0] n3_d;
  logic [7:0] d1_d;
  logic [1:0] n3_y, n3_sel, d1_y, d1_sel;
  logic       n3_chg, d1_chg;

  mux_scan_reg #(.W(W), .N(N), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel_in(sel_in), .step(step),
    .y(y), .sel(sel), .chg(chg)
  );

  mux_scan_reg #(.W(2), .N(3), .DWELL(4)) dut_n3 (
    .clk(clk), .rst_n(n3_rst_n), .d(n3_d), .mode(n3_mode), .sel_in(n3_sel_in), .step(aux_step),
    .y(n3_y), .sel(n3_sel), .chg(n3_chg)
  );

  mux_scan_reg #(.W(2), .N(4), .DWELL(1)) dut_d1 (
    .clk(clk), .rst_n(d1_rst_n), .d(d1_d), .mode(d1_mode), .sel_in(d1_sel_in), .step(aux_step),
    .y(d1_y), .sel(d1_sel), .chg(d1_chg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model of the main instance, stepped once per rising edge.
  int m_sel = 0, m_y = 0, m_chg = 0, m_dwell = 0, m_prev_step = 0;
  always @(posedge clk) begin
    int cur, nxt;
    if (!rst_n) begin
      m_sel = 0; m_y = 0; m_chg = 0; m_dwell = 0; m_prev_step = 0;
    end else begin
      cur = m_sel;
      nxt = cur;
      case (mode)
        2'd0: if (int'(sel_in) < N) nxt = int'(sel_in);
        2'd1: begin
          m_dwell = m_dwell + 1;
          if (m_dwell == DWELL) begin
            m_dwell = 0;
            nxt = (cur + 1) % N;
          end
        end
        2'd2: if (step && m_prev_step == 0) nxt = (cur + 1) % N;
        default: ;
      endcase
      if (mode != 2'd1) m_dwell = 0;
      if (mode != 2'd3) m_y = int'((d >> (cur * W)) & 8'(((1 << W) - 1)));
      m_chg = (nxt != cur) ? 1 : 0;
      m_sel = nxt;
      m_prev_step = step ? 1 : 0;
    end
  end

  typedef struct {
    logic       rst_n;
    logic [1:0] mode;
    logic [1:0] sel_in;
    logic       step;
    logic [7:0] d;
    logic [1:0] e_sel;
    logic [1:0] e_y;
    logic       e_chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] m, input logic [1:0] si, input logic st,
                     input logic [7:0] dd, input logic [1:0] es, input logic [1:0] ey, input logic ec);
    vec_t v;
    v.rst_n = r; v.mode = m; v.sel_in = si; v.step = st; v.d = dd;
    v.e_sel = es; v.e_y = ey; v.e_chg = ec;
    vecs.push_back(v);
  endtask

  localparam logic [7:0] DA = 8'h1B;  // ch0=3 ch1=2 ch2=1 ch3=0
  localparam logic [7:0] DB = 8'hE4;  // ch0=0 ch1=1 ch2=2 ch3=3

  initial begin
    rst_n = 1'b0; mode = 2'd0; sel_in = 2'd0; step = 1'b0; d = DA;
    aux_step = 1'b0;
    n3_rst_n = 1'b0; n3_mode = 2'd0; n3_sel_in = 2'd0; n3_d = 6'b01_10_00;
    d1_rst_n = 1'b0; d1_mode = 2'd1; d1_sel_in = 2'd0; d1_d = DA;

    // reset, then manual selection
    add(0,0,0,0,DA, 0,0,0);
    add(0,0,0,0,DA, 0,0,0);
    add(1,0,0,0,DA, 0,3,0);
    add(1,0,2,0,DA, 2,3,1);
    add(1,0,2,0,DA, 2,1,0);
    add(1,0,2,0,DA, 2,1,0);
    add(1,0,3,0,DA, 3,1,1);
    add(1,0,0,0,DA, 0,0,1);
    add(1,0,0,0,DA, 0,3,0);
    // auto-scan from sel=0: advance on edges 4, 8, 12, 16
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) add(1,1,0,0,DA, 2'(k), 2'(3 - k), 0);
      add(1,1,0,0,DA, 2'((k + 1) % 4), 2'(3 - k), 1);
    end
    add(1,1,0,0,DA, 0,3,0);
    // step mode entered with step already high
    add(1,0,0,1,DA, 0,3,0);
    add(1,2,0,1,DA, 0,3,0);
    add(1,2,0,0,DA, 0,3,0);
    for (int k = 0; k < 4; k++) begin
      add(1,2,0,1,DA, 2'((k + 1) % 4), 2'(3 - k), 1);
      add(1,2,0,0,DA, 2'((k + 1) % 4), 2'(3 - ((k + 1) % 4)), 0);
    end
    add(1,2,0,1,DA, 1,3,1);
    add(1,2,0,1,DA, 1,2,0);
    // hold ignores data changes, then data propagates once out of hold
    add(1,3,0,0,DB, 1,2,0);
    add(1,3,0,0,DB, 1,2,0);
    add(1,2,0,0,DB, 1,1,0);
    // reset in the middle of a dwell
    add(1,0,2,0,DB, 2,1,1);
    add(1,1,0,0,DB, 2,2,0);
    add(1,1,0,0,DB, 2,2,0);
    add(0,1,0,0,DB, 0,0,0);
    add(1,1,0,0,DB, 0,0,0);
    add(1,1,0,0,DB, 0,0,0);
    add(1,1,0,0,DB, 0,0,0);
    add(1,1,0,0,DB, 1,0,1);
    add(1,1,0,0,DB, 1,1,0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; mode = vecs[i].mode; sel_in = vecs[i].sel_in;
      step = vecs[i].step; d = vecs[i].d;
      tick();
      check($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].e_sel));
      check($sformatf("vec%0d y", i),   32'(y),   32'(vecs[i].e_y));
      check($sformatf("vec%0d chg", i), 32'(chg), 32'(vecs[i].e_chg));
    end

    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) step = ~step;
      if ($urandom_range(0, 3) == 0) d = 8'($urandom);
      tick();
      check($sformatf("rnd%0d sel", c), 32'(sel), 32'(m_sel));
      check($sformatf("rnd%0d y", c),   32'(y),   32'(m_y));
      check($sformatf("rnd%0d chg", c), 32'(chg), 32'(m_chg));
    end

    // N=3: out-of-range request ignored, hold freezes y, step wraps at 2
    tick();
    check("n3 reset sel", 32'(n3_sel), 32'd0);
    check("n3 reset y", 32'(n3_y), 32'd0);
    n3_rst_n = 1'b1; n3_sel_in = 2'd1;
    tick();
    check("n3 load sel", 32'(n3_sel), 32'd1);
    check("n3 load chg", 32'(n3_chg), 32'd1);
    n3_sel_in = 2'd3;
    tick();
    check("n3 oor sel", 32'(n3_sel), 32'd1);
    check("n3 oor chg", 32'(n3_chg), 32'd0);
    check("n3 oor y", 32'(n3_y), 32'd2);
    n3_mode = 2'd3; n3_d = 6'b00_01_11;
    tick();
    tick();
    check("n3 hold y", 32'(n3_y), 32'd2);
    check("n3 hold sel", 32'(n3_sel), 32'd1);
    n3_mode = 2'd2;
    tick();
    check("n3 new data y", 32'(n3_y), 32'd1);
    aux_step = 1'b1;
    tick();
    check("n3 step sel", 32'(n3_sel), 32'd2);
    aux_step = 1'b0;
    tick();
    aux_step = 1'b1;
    tick();
    check("n3 wrap sel", 32'(n3_sel), 32'd0);
    check("n3 wrap chg", 32'(n3_chg), 32'd1);
    aux_step = 1'b0;

    // DWELL=1: advance on every cycle
    tick();
    check("d1 reset sel", 32'(d1_sel), 32'd0);
    d1_rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("d1 sel%0d", i), 32'(d1_sel), 32'(i % 4));
      check($sformatf("d1 chg%0d", i), 32'(d1_chg), 32'd1);
      check($sformatf("d1 y%0d", i),   32'(d1_y),   32'(3 - ((i - 1) % 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
